effect_echo: RTL and testbench

Echo stage directly downstream of the loop stage. Consumes its `o_data`/`o_valid` sample stream and keeps a circular delay line in the reserved external SRAM region (addresses 0–31999, below the loop region). Produces `x + level·delayed/8` with feedback. The wet result is written back into the delay line, so echoes decay over repeats.

---
 rtl/effect_echo_pkg.sv | 30 +++
 rtl/effect_echo_mixer.sv | 34 +++
 rtl/effect_echo.sv | 167 ++++++++++++++++
 tb/tb_effect_echo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/effect_echo_pkg.sv
// effect_echo_pkg
// Shared definitions for the echo stage: FSM state encoding, default
// delay-line geometry and the 16-bit saturation helper used by the mixer.
package effect_echo_pkg;

    localparam int BUF_DEPTH_DEF  = 32000;
    localparam int DELAY_STEP_DEF = 4000;
    localparam int BASE_ADDR_DEF  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ_REQ,
        S_READ_LATCH,
        S_MIX,
        S_WRITE
    } state_t;

    // Clamp a 19-bit signed sum into the signed 16-bit sample range.
    function automatic logic [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'sh07FFF) begin
            return 16'h7FFF;
        end else if (v < 19'sh78000) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/effect_echo_mixer.sv
// echo_mixer
// Combinational wet mix: y = sat16(x + ((d * lvl) >>> 3)).
// Ports:
//   x_i   : signed 16-bit dry input sample
//   d_i   : signed 16-bit delayed sample read from the delay line
//   lvl_i : unsigned 3-bit weight in eighths
//   y_o   : signed 16-bit saturated result
import effect_echo_pkg::*;

module echo_mixer (
    input  logic [15:0] x_i,
    input  logic [15:0] d_i,
    input  logic [2:0]  lvl_i,
    output logic [15:0] y_o
);

    logic signed [18:0] d_ext;
    logic signed [18:0] lvl_ext;
    logic signed [18:0] prod;
    logic signed [18:0] scaled;
    logic signed [18:0] x_ext;
    logic signed [18:0] sum;

    // |d * lvl| <= 32768 * 7 fits in 19 signed bits, so no product bits are lost.
    assign d_ext   = {{3{d_i[15]}}, d_i};
    assign lvl_ext = {16'd0, lvl_i};
    assign prod    = d_ext * lvl_ext;
    // Arithmetic shift rounds toward minus infinity for negative products.
    assign scaled  = prod >>> 3;
    assign x_ext   = {{3{x_i[15]}}, x_i};
    assign sum     = x_ext + scaled;
    assign y_o     = sat16(sum);

endmodule

// File: rtl/effect_echo.sv
// effect_echo
// Echo stage with a circular delay line in external SRAM. Each captured
// sample reads the slot 'dly' samples back, mixes it in, outputs the wet
// result and writes it back so echoes decay on every repeat. A 0->1 edge of
// i_enable first zero-fills the whole delay line.
// Ports:
//   i_clk, i_rst_n       : clock, synchronous active-low reset
//   i_valid, i_data      : input sample strobe and signed sample
//   i_enable             : 1 = echo, 0 = bypass
//   i_level, i_delay_sel : wet weight (eighths) and delay step select
//   i_sram_rdata         : SRAM read data
//   o_sram_addr/we_n/wdata : SRAM address, active-low write enable, write data
//   o_data, o_valid      : output sample and strobe
import effect_echo_pkg::*;

module effect_echo #(
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter int BASE_ADDR  = BASE_ADDR_DEF,
    parameter int DELAY_STEP = DELAY_STEP_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_enable,
    input  logic [2:0]  i_level,
    input  logic [2:0]  i_delay_sel,
    input  logic [15:0] i_data,
    input  logic [15:0] i_sram_rdata,
    output logic [19:0] o_sram_addr,
    output logic        o_sram_we_n,
    output logic [15:0] o_sram_wdata,
    output logic [15:0] o_data,
    output logic        o_valid
);

    localparam logic [19:0] DEPTH = 20'(BUF_DEPTH);
    localparam logic [19:0] LAST  = 20'(BUF_DEPTH - 1);
    localparam logic [19:0] BASE  = 20'(BASE_ADDR);
    localparam logic [19:0] STEP  = 20'(DELAY_STEP);

    state_t      state_q, state_d;
    logic        enable_q;
    logic [19:0] wptr_q, wptr_d;
    logic [19:0] clr_cnt_q, clr_cnt_d;
    logic [15:0] o_data_q, o_data_d;
    logic        byp_vld_q, byp_vld_d;
    logic [15:0] x_q, x_d;
    logic [2:0]  lvl_q, lvl_d;
    logic [19:0] dly_q, dly_d;
    logic [15:0] dat_q, dat_d;

    logic        en_rise;
    logic [19:0] rptr;
    logic [15:0] mix_y;

    assign en_rise = i_enable & ~enable_q;

    // Read slot lags the write slot by dly, wrapping below slot 0.
    assign rptr = (wptr_q >= dly_q) ? (wptr_q - dly_q) : (wptr_q + DEPTH - dly_q);

    echo_mixer u_mixer (
        .x_i   (x_q),
        .d_i   (dat_q),
        .lvl_i (lvl_q),
        .y_o   (mix_y)
    );

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        clr_cnt_d    = clr_cnt_q;
        o_data_d     = o_data_q;
        byp_vld_d    = 1'b0;
        x_d          = x_q;
        lvl_d        = lvl_q;
        dly_d        = dly_q;
        dat_d        = dat_q;
        o_sram_addr  = 20'd0;
        o_sram_we_n  = 1'b1;
        o_sram_wdata = 16'd0;

        case (state_q)
            S_IDLE: begin
                if (en_rise) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = 20'd0;
                end else if (i_valid && enable_q) begin
                    // Controls are sampled here only; later changes wait for the next sample.
                    x_d     = i_data;
                    lvl_d   = i_level;
                    dly_d   = ({17'd0, i_delay_sel} + 20'd1) * STEP;
                    state_d = S_READ_REQ;
                end
            end
            S_CLEAR: begin
                o_sram_addr = BASE + clr_cnt_q;
                o_sram_we_n = 1'b0;
                if (clr_cnt_q == LAST) begin
                    state_d   = S_IDLE;
                    clr_cnt_d = 20'd0;
                    wptr_d    = 20'd0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 20'd1;
                end
            end
            S_READ_REQ: begin
                o_sram_addr = BASE + rptr;
                state_d     = S_READ_LATCH;
            end
            S_READ_LATCH: begin
                o_sram_addr = BASE + rptr;
                dat_d       = i_sram_rdata;
                state_d     = S_MIX;
            end
            S_MIX: begin
                o_data_d = mix_y;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                o_sram_addr  = BASE + wptr_q;
                o_sram_we_n  = 1'b0;
                o_sram_wdata = o_data_q;
                wptr_d       = (wptr_q == LAST) ? 20'd0 : (wptr_q + 20'd1);
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bypass never touches the SRAM or the write pointer.
        if (i_valid && (((state_q == S_IDLE) && !enable_q) || (state_q == S_CLEAR))) begin
            byp_vld_d = 1'b1;
            o_data_d  = i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            enable_q  <= 1'b0;
            wptr_q    <= 20'd0;
            clr_cnt_q <= 20'd0;
            o_data_q  <= 16'd0;
            byp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            enable_q  <= i_enable;
            wptr_q    <= wptr_d;
            clr_cnt_q <= clr_cnt_d;
            o_data_q  <= o_data_d;
            byp_vld_q <= byp_vld_d;
        end
    end

    // Sample-path holding registers are always rewritten before use.
    always_ff @(posedge i_clk) begin
        x_q   <= x_d;
        lvl_q <= lvl_d;
        dly_q <= dly_d;
        dat_q <= dat_d;
    end

    assign o_data  = o_data_q;
    assign o_valid = byp_vld_q | (state_q == S_WRITE);

endmodule

// File: tb/tb_effect_echo.sv
// tb_effect_echo
// Directed bench for effect_echo with a registered-read SRAM model and a
// scoreboard of expected output samples.
module tb_effect_echo;

    localparam int D    = 3200;
    localparam int STEP = 400;
    localparam int BASE = 0;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        enable;
    logic [2:0]  level;
    logic [2:0]  dsel;
    logic [15:0] data;
    logic [15:0] rdata;
    logic [19:0] addr;
    logic        we_n;
    logic [15:0] wdata;
    logic [15:0] odata;
    logic        ovalid;

    logic [15:0] mem [0:D-1];
    logic        pl_en;
    int          pl_a;
    logic [15:0] pl_v;

    int n_checks;
    int n_errs;
    int wptr_exp;
    logic signed [15:0] sb_q [$];

    effect_echo #(.BUF_DEPTH(D), .BASE_ADDR(BASE), .DELAY_STEP(STEP)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (valid),
        .i_enable     (enable),
        .i_level      (level),
        .i_delay_sel  (dsel),
        .i_data       (data),
        .i_sram_rdata (rdata),
        .o_sram_addr  (addr),
        .o_sram_we_n  (we_n),
        .o_sram_wdata (wdata),
        .o_data       (odata),
        .o_valid      (ovalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_a] <= pl_v;
        end else if (!we_n && (addr < 20'(D))) begin
            mem[addr] <= wdata;
        end
        rdata <= (addr < 20'(D)) ? mem[addr] : 16'hDEAD;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rptr_of(input int wp, input int sel);
        int dl;
        dl = (sel + 1) * STEP;
        return (wp >= dl) ? (wp - dl) : (wp + D - dl);
    endfunction

    task automatic preload(input int a, input int v);
        pl_a  = a;
        pl_v  = 16'(v);
        pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Drive one sample, wait for its output and compare against the scoreboard.
    task automatic send(input int x, input int lvl, input int sel, input int exp,
                        input bit echo, input bit drop_en, input string tag);
        int n;
        int rp;
        logic signed [15:0] e;
        rp = rptr_of(wptr_exp, sel);
        sb_q.push_back(16'(exp));
        valid = 1'b1;
        data  = 16'(x);
        level = 3'(lvl);
        dsel  = 3'(sel);
        n = 0;
        do begin
            @(negedge clk);
            if (n == 0) begin
                valid = 1'b0;
                data  = 16'($urandom);
                level = 3'($urandom);
                dsel  = 3'($urandom);
            end
            n++;
            if (drop_en && n == 1) enable = 1'b0;
            if (echo && (n == 1 || n == 2) && !ovalid) begin
                chk({tag, "_raddr"}, addr, BASE + rp);
                chk({tag, "_rd_we_n"}, we_n, 1);
            end
        end while (!ovalid && n < 12);
        chk({tag, "_lat"}, n, echo ? 4 : 1);
        if (ovalid) begin
            e = sb_q.pop_front();
            chk(tag, $signed(odata), e);
            if (echo) begin
                chk({tag, "_waddr"}, addr, BASE + wptr_exp);
                chk({tag, "_we_n"}, we_n, 0);
                chk({tag, "_wdata"}, $signed(wdata), e);
                wptr_exp = (wptr_exp == D - 1) ? 0 : wptr_exp + 1;
            end else begin
                chk({tag, "_byp_we_n"}, we_n, 1);
            end
        end else if (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
        @(negedge clk);
    endtask

    // Expects the clear to start on the posedge following the current negedge.
    task automatic do_clear(input string tag, input bit inject);
        int good;
        logic signed [15:0] e;
        good = 0;
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            if (!we_n && addr == 20'(BASE + i) && wdata == 16'd0) good++;
            if (inject && i == 101) begin
                chk({tag, "_byp_vld"}, ovalid, 1);
                e = sb_q.pop_front();
                chk({tag, "_byp_data"}, $signed(odata), e);
            end
            if (inject && i == 100) begin
                valid = 1'b1;
                data  = 16'(-500);
                sb_q.push_back(-16'sd500);
            end else begin
                valid = 1'b0;
            end
        end
        chk({tag, "_writes"}, good, D);
        @(negedge clk);
        chk({tag, "_idle_we_n"}, we_n, 1);
        chk({tag, "_idle_addr"}, addr, 0);
        wptr_exp = 0;
    endtask

    initial begin
        int x;
        int bad;
        n_checks = 0;
        n_errs   = 0;
        wptr_exp = 0;
        pl_en    = 1'b0;
        pl_a     = 0;
        pl_v     = 16'd0;
        rst_n    = 1'b0;
        valid    = 1'b0;
        enable   = 1'b0;
        level    = 3'd0;
        dsel     = 3'd0;
        data     = 16'd0;

        repeat (3) @(negedge clk);
        chk("rst_o_data", odata, 0);
        chk("rst_o_valid", ovalid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_we_n", we_n, 1);
        chk("rst_wdata", wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(1234, 0, 0, 1234, 0, 0, "byp_1234");
        send(-7, 5, 3, -7, 0, 0, "byp_neg");

        enable = 1'b1;
        do_clear("clear1", 1);

        for (int k = 0; k <= 1600; k++) begin
            x = (k == 0) ? 8000 : 0;
            send(x, 4, 0, (k % 400 == 0) ? (8000 >> (k / 400)) : 0, 1, 0, "echo");
        end

        preload(rptr_of(wptr_exp, 0), 32767);
        send(30000, 7, 0, 32767, 1, 0, "sat_pos");
        preload(rptr_of(wptr_exp, 0), -32768);
        send(-30000, 7, 0, -32768, 1, 0, "sat_neg");
        preload(rptr_of(wptr_exp, 0), -1001);
        send(0, 3, 0, -376, 1, 0, "neg_shift");
        preload(rptr_of(wptr_exp, 0), 5000);
        send(123, 0, 0, 123, 1, 0, "lvl0");

        while (wptr_exp != D - 1) begin
            x = $urandom_range(0, 2000) - 1000;
            send(x, 0, 0, x, 1, 0, "adv1");
        end
        preload(D - 1, 800);
        send(0, 4, 7, 400, 1, 0, "wrap_sel7");
        chk("wrap_wptr0", wptr_exp, 0);
        send(50, 0, 0, 50, 1, 0, "wrap_next");
        while (wptr_exp != 100) begin
            x = $urandom_range(0, 2000) - 1000;
            send(x, 0, 0, x, 1, 0, "adv2");
        end
        preload(2900, -16);
        send(10, 2, 0, 6, 1, 0, "rptr_100");

        send(300, 0, 0, 300, 1, 1, "en_fall");
        send(77, 0, 0, 77, 0, 0, "byp_after");
        enable = 1'b1;
        do_clear("clear2", 0);

        valid = 1'b1;
        data  = 16'd999;
        level = 3'd7;
        dsel  = 3'd0;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_o_data", odata, 0);
        chk("mid_rst_o_valid", ovalid, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_we_n", we_n, 1);
        chk("mid_rst_wdata", wdata, 0);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (ovalid !== 1'b0 || we_n !== 1'b1) bad++;
        end
        chk("mid_rst_quiet", bad, 0);
        rst_n = 1'b1;
        do_clear("clear3", 0);
        send(555, 7, 0, 555, 1, 0, "post_clear");

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
